wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back end of the OpenMIPS pipeline. It holds the 32×32 general-purpose register file and the HI/LO pair, and commits the writes presented by the MEM/WB stage register. It serves two combinational GPR read ports to the ID stage and a HI/LO read port to the EX stage. Same-cycle write-to-read bypass is built in, so a value being written back is visible to a dependent read in the same cycle.

## Interface
Parameters (values come from `define.v`):
- `RegNum`, 32: number of GPRs.
- `RegNumLog2`, 5: GPR address width (`RegAddrBus`).
- `RegWidth`, 32: data width (`RegBus`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `we`  in  1  GPR write enable (from `wb_wreg`).
- `waddr`  in  5  GPR write address (from `wb_wd`).
- `wdata`  in  32  GPR write data (from `wb_wdata`).
- `re1`  in  1  read port 1 enable.
- `raddr1`  in  5  read port 1 address.
- `rdata1`  out  32  read port 1 data.
- `re2`  in  1  read port 2 enable.
- `raddr2`  in  5  read port 2 address.
- `rdata2`  out  32  read port 2 data.
- `whilo`  in  1  HI/LO write enable (from `wb_whilo`).
- `hi_i`  in  32  HI write data (from `wb_hi`).
- `lo_i`  in  32  LO write data (from `wb_lo`).
- `hi_o`  out  32  current HI, bypassed.
- `lo_o`  out  32  current LO, bypassed.

## Operation
**GPR write**
- At a rising edge with `rst`=0, `we`=1 and `waddr`≠0: `regs[waddr]` ← `wdata`.
- Writes to r0 are discarded; r0 always reads 0.

**GPR read** (each port independent and combinational). Priority order:
1. `rst`=1 → 0.
2. `raddr`=0 → 0.
3. `re`=0 → 0.
4. `we`=1 and `waddr`=`raddr` → `wdata` (bypass).
5. Otherwise → `regs[raddr]`.

Both ports may read the same address, and both may bypass in the same cycle.

**HI/LO**
- At a rising edge with `rst`=0 and `whilo`=1: HI ← `hi_i` and LO ← `lo_i`. Both are always written together.
- `hi_o`/`lo_o`:
  - `rst`=1 → 0.
  - `whilo`=1 → `hi_i`/`lo_i` (bypass).
  - Otherwise → the stored values.

**Reset**
- A rising edge with `rst`=1 clears all 31 writable GPRs, HI and LO to 0.
- Any write presented in that cycle is dropped.

## Timing
- Write latency: one edge. Data presented in cycle N is stored at the end of cycle N.
- Read latency: zero (combinational). Through the bypass, a read sees cycle N write data in cycle N itself.
- Reset value of every output: 0 while `rst` is high. Outputs stay 0 after reset until a write occurs.
- Reset asserted mid-stream: the pending write is lost, and the read outputs are forced to 0 in that same cycle (the bypass is also suppressed).
- Simultaneous `we` and `whilo` are independent, and both commit on the same edge.
- Back-to-back writes to the same address: the last write wins. A read in each cycle returns that cycle's `wdata`.
- No handshake: writes are always accepted and there is no stall output.

## Structure
Shared constants in `define.v`:
- Widths: `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`.
- Values: `ZeroWord`, `NOPRegAddr`.
- Polarities: `RstEnable`, `WriteEnable`, `ReadEnable`, `WriteDisable`, `ReadDisable`.

The block contains no new constants.

Sub-module: `hilo_reg` holds the HI/LO pair with its bypass, and is instantiated once. The GPR array and the read muxes stay in the top level.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `we`=1, `waddr`=5, `wdata`=0xDEADBEEF.
  - Required: `rdata1`=0 during reset.
  - Required: after release, reading r5 returns 0.
- **Write then read:** write r7=0x12345678 in cycle N; in cycle N+1 `re1`=1, `raddr1`=7.
  - Required: `rdata1`=0x12345678.
  - Required: `re1`=0 gives 0.
- **r0 protection:** write r0=0xFFFFFFFF.
  - Required: reads of r0 return 0, both in the same cycle (no bypass) and later.
- **Dual-port bypass:** `we`=1, `waddr`=3, `wdata`=0xA5A5A5A5 while `raddr1`=`raddr2`=3 and r3 holds 0x1.
  - Required: both ports read 0xA5A5A5A5 in the same cycle.
  - Required: the next cycle also reads 0xA5A5A5A5 from storage.
- **HI/LO:** `whilo`=1, `hi_i`=0x11, `lo_i`=0x22.
  - Required: `hi_o`/`lo_o` show 0x11/0x22 in that cycle and hold them after `whilo` drops.
  - Required: a later `rst` pulse returns both to 0.
- **Concurrent writes:** in one cycle, `we` writes r31=0x80000000 and `whilo` writes HI=0xCAFE, LO=0xBABE.
  - Required: both land on the same edge and read back correctly.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and constants for the write-back register file
package wb_regfile_pkg;
  localparam int RegNum = 32;
  localparam int RegNumLog2 = 5;
  localparam int RegWidth = 32;
  localparam logic [RegWidth-1:0] ZeroWord = '0;
  localparam logic [RegNumLog2-1:0] NOPRegAddr = '0;
endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// hilo_reg: HI/LO register pair with same-cycle write bypass
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [RegWidth-1:0] hi_i,
  input  logic [RegWidth-1:0] lo_i,
  output logic [RegWidth-1:0] hi_o,
  output logic [RegWidth-1:0] lo_o
);
  logic [RegWidth-1:0] hi, lo;
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= ZeroWord;
      lo <= ZeroWord;
    end else if (we) begin
      hi <= hi_i;
      lo <= lo_i;
    end
  end
  always_comb begin
    hi_o = rst ? ZeroWord : we ? hi_i : hi;
    lo_o = rst ? ZeroWord : we ? lo_i : lo;
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 GPR file plus HI/LO with write-to-read bypass for the WB stage
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [RegNumLog2-1:0] waddr,
  input  logic [RegWidth-1:0]   wdata,
  input  logic                  re1,
  input  logic [RegNumLog2-1:0] raddr1,
  output logic [RegWidth-1:0]   rdata1,
  input  logic                  re2,
  input  logic [RegNumLog2-1:0] raddr2,
  output logic [RegWidth-1:0]   rdata2,
  input  logic                  whilo,
  input  logic [RegWidth-1:0]   hi_i,
  input  logic [RegWidth-1:0]   lo_i,
  output logic [RegWidth-1:0]   hi_o,
  output logic [RegWidth-1:0]   lo_o
);
  logic [RegWidth-1:0] regs [RegNum];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RegNum; i++) regs[i] <= ZeroWord;
    end else if (we && waddr != NOPRegAddr) begin
      regs[waddr] <= wdata;
    end
  end
  always_comb begin
    rdata1 = (rst || raddr1 == NOPRegAddr || !re1) ? ZeroWord :
             (we && waddr == raddr1) ? wdata : regs[raddr1];
    rdata2 = (rst || raddr2 == NOPRegAddr || !re2) ? ZeroWord :
             (we && waddr == raddr2) ? wdata : regs[raddr2];
  end
  hilo_reg u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (whilo),
    .hi_i (hi_i),
    .lo_i (lo_i),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile
module tb_wb_regfile;
  logic        clk = 0;
  logic        rst, we, re1, re2, whilo;
  logic [4:0]  waddr, raddr1, raddr2;
  logic [31:0] wdata, hi_i, lo_i, rdata1, rdata2, hi_o, lo_o;
  int checks = 0;
  int failures = 0;
  wb_regfile dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re1    (re1),
    .raddr1 (raddr1),
    .rdata1 (rdata1),
    .re2    (re2),
    .raddr2 (raddr2),
    .rdata2 (rdata2),
    .whilo  (whilo),
    .hi_i   (hi_i),
    .lo_i   (lo_i),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic next_cycle();
    @(negedge clk);
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    rst = 1; we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 5;
    whilo = 1; hi_i = 32'h77; lo_i = 32'h66;
    settle();
    chk("rst_rdata1", rdata1, 0);
    chk("rst_rdata2", rdata2, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    next_cycle(); settle();
    chk("rst_rdata1_c2", rdata1, 0);
    next_cycle();
    rst = 0; we = 0; whilo = 0; settle();
    chk("post_rst_r5", rdata1, 0);
    chk("post_rst_hi", hi_o, 0);
    chk("post_rst_lo", lo_o, 0);
    we = 1; waddr = 7; wdata = 32'h12345678; raddr1 = 5;
    next_cycle();
    we = 0; raddr1 = 7; settle();
    chk("r7_read", rdata1, 32'h12345678);
    re1 = 0; settle();
    chk("r7_re_off", rdata1, 0);
    re1 = 1; re2 = 1; raddr1 = 0; raddr2 = 0;
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; settle();
    chk("r0_bypass_p1", rdata1, 0);
    chk("r0_bypass_p2", rdata2, 0);
    next_cycle();
    we = 0; settle();
    chk("r0_later_p1", rdata1, 0);
    chk("r0_later_p2", rdata2, 0);
    we = 1; waddr = 3; wdata = 32'h1;
    next_cycle();
    we = 0; raddr1 = 3; raddr2 = 3; settle();
    chk("r3_init", rdata1, 32'h1);
    we = 1; wdata = 32'hA5A5A5A5; settle();
    chk("dual_byp_p1", rdata1, 32'hA5A5A5A5);
    chk("dual_byp_p2", rdata2, 32'hA5A5A5A5);
    next_cycle();
    we = 0; settle();
    chk("dual_store_p1", rdata1, 32'hA5A5A5A5);
    chk("dual_store_p2", rdata2, 32'hA5A5A5A5);
    whilo = 1; hi_i = 32'h11; lo_i = 32'h22; settle();
    chk("hilo_byp_hi", hi_o, 32'h11);
    chk("hilo_byp_lo", lo_o, 32'h22);
    next_cycle();
    whilo = 0; hi_i = 32'h99; lo_i = 32'h88; settle();
    chk("hilo_hold_hi", hi_o, 32'h11);
    chk("hilo_hold_lo", lo_o, 32'h22);
    we = 1; waddr = 9; wdata = 32'h55; raddr1 = 9; raddr2 = 7;
    rst = 1; settle();
    chk("mid_rst_byp", rdata1, 0);
    chk("mid_rst_hi", hi_o, 0);
    next_cycle();
    rst = 0; we = 0; settle();
    chk("mid_rst_r9_lost", rdata1, 0);
    chk("mid_rst_r7_clr", rdata2, 0);
    chk("rst_pulse_hi", hi_o, 0);
    chk("rst_pulse_lo", lo_o, 0);
    we = 1; waddr = 31; wdata = 32'h80000000;
    whilo = 1; hi_i = 32'hCAFE; lo_i = 32'hBABE;
    next_cycle();
    we = 0; whilo = 0; hi_i = 0; lo_i = 0; raddr2 = 31; settle();
    chk("conc_r31", rdata2, 32'h80000000);
    chk("conc_hi", hi_o, 32'hCAFE);
    chk("conc_lo", lo_o, 32'hBABE);
    we = 1; waddr = 4; wdata = 32'h1; raddr1 = 4; settle();
    chk("b2b_1", rdata1, 32'h1);
    next_cycle();
    wdata = 32'h2; settle();
    chk("b2b_2", rdata1, 32'h2);
    next_cycle();
    we = 0; settle();
    chk("b2b_final", rdata1, 32'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
